counter_uart_reporter: RTL and testbench

COUNTER_UART_REPORTER -- requirements
Module: counter_uart_reporter

---
 rtl/counter_uart_pkg.sv | 31 +++
 rtl/uart_tx_byte.sv | 129 ++++++++++++
 rtl/counter_uart_reporter.sv | 107 ++++++++++
 tb/tb_counter_uart_reporter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_uart_pkg
//  Description : Shared definitions for the counter UART reporter: serializer
//                state encoding, line-ending characters and the nibble to
//                uppercase ASCII hex conversion.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic [7:0] c_CR = 8'h0D;
    localparam logic [7:0] c_LF = 8'h0A;

    // '0'..'9' for 0..9, 'A'..'F' for 10..15
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_byte
//  Description : 8N1 byte serializer. A byte is accepted when i_start is high
//                while o_ready is high. o_ready is also high in the last cycle
//                of a stop bit, so a byte offered then starts immediately with
//                no idle gap between frames of back-to-back bytes.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                i_start, i_data - byte request and its payload
//                o_ready         - a request is accepted this cycle
//                o_byte_done     - last cycle of the current stop bit
//                o_busy          - serializer not idle
//                o_tx            - serial line, idle high
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte
    import counter_uart_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_byte_done,
    output logic       o_busy,
    output logic       o_tx
);

    localparam int                 c_CNT_W     = $clog2(DIV);
    localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(DIV - 1);

    state_t             r_state;
    logic [c_CNT_W-1:0] r_baud_cnt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic               r_tx;

    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] w_baud_nxt;
    logic [2:0]         w_bit_nxt;
    logic [7:0]         w_shift_nxt;
    logic               w_tx_nxt;
    logic               w_bit_end;

    // Baud counter is held at zero in IDLE, so a new bit always lasts DIV cycles
    assign w_bit_end   = (r_state != ST_IDLE) && (r_baud_cnt == c_BAUD_LAST);
    assign o_byte_done = (r_state == ST_STOP) && w_bit_end;
    assign o_ready     = (r_state == ST_IDLE) || o_byte_done;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_tx        = r_tx;

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        if (r_state == ST_IDLE || w_bit_end) begin
            w_baud_nxt = '0;
        end else begin
            w_baud_nxt = r_baud_cnt + c_CNT_W'(1);
        end

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_START;
                    w_shift_nxt = i_data;
                    w_tx_nxt    = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_DATA;
                    w_tx_nxt    = r_shift[0];
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_bit_nxt   = 3'd0;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = ST_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_tx_nxt    = r_shift[0];
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_bit_nxt   = r_bit_cnt + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (i_start) begin
                        w_state_nxt = ST_START;
                        w_shift_nxt = i_data;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/counter_uart_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : counter_uart_reporter
//  Description : Watches an 8-bit counter value and, whenever it differs from
//                the last reported value, sends "HH\r\n" (uppercase hex) over
//                an 8N1 UART. Changes during a frame coalesce into one
//                follow-up frame carrying the value seen when it starts.
//  Ports       : clk, rst_n  - clock, async active-low reset
//                value       - counter value to report
//                tx          - UART line, idle high
//                busy        - a frame is in progress
//                frame_done  - one-cycle pulse when a frame completes
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_uart_reporter
    import counter_uart_pkg::*;
#(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] value,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int c_DIV = CLK_FREQ / BAUD_RATE;

    generate
        if (c_DIV < 4) begin : g_div_check
            $error("counter_uart_reporter: CLK_FREQ/BAUD_RATE must be at least 4");
        end
    endgenerate

    logic [7:0] r_last_sent;
    logic       r_pending;
    logic [1:0] r_byte_idx;
    logic       r_frame_done;

    logic       w_ready;
    logic       w_byte_done;
    logic       w_busy;
    logic       w_start_frame;
    logic       w_next_byte;
    logic       w_start;
    logic [7:0] w_byte_data;

    assign w_start_frame = !w_busy && r_pending;
    assign w_next_byte   = w_byte_done && (r_byte_idx != 2'd3);
    assign w_start       = w_ready && (w_start_frame || w_next_byte);

    // The first byte of a frame is built from the live value because the
    // snapshot register loads on the same edge the frame starts.
    always_comb begin
        w_byte_data = hex_ascii(value[7:4]);
        if (!w_start_frame) begin
            case (r_byte_idx)
                2'd0:    w_byte_data = hex_ascii(r_last_sent[3:0]);
                2'd1:    w_byte_data = c_CR;
                default: w_byte_data = c_LF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_sent  <= 8'h00;
            r_pending    <= 1'b1;
            r_byte_idx   <= 2'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_byte_done && (r_byte_idx == 2'd3);
            if (w_start_frame) begin
                r_last_sent <= value;
                r_pending   <= 1'b0;
                r_byte_idx  <= 2'd0;
            end else begin
                // Tracks the comparison each cycle, so a return to the
                // reported value before the next frame cancels it.
                r_pending <= (value != r_last_sent);
                if (w_next_byte) begin
                    r_byte_idx <= r_byte_idx + 2'd1;
                end
            end
        end
    end

    uart_tx_byte #(
        .DIV (c_DIV)
    ) u_tx_byte (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_start),
        .i_data      (w_byte_data),
        .o_ready     (w_ready),
        .o_byte_done (w_byte_done),
        .o_busy      (w_busy),
        .o_tx        (tx)
    );

    assign busy       = w_busy;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_counter_uart_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_uart_reporter
//  Description : Self-checking bench for counter_uart_reporter. Expected line
//                waveforms are computed from the frame format (start bit,
//                LSB-first data, stop bit, "HH\r\n") by plain arithmetic.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_uart_reporter;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int DIV       = CLK_FREQ / BAUD_RATE;
    localparam int BYTE_CYC  = 10 * DIV;
    localparam int FRAME_CYC = 4 * BYTE_CYC;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] value = 8'h00;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] sent_last = 8'h00;
    int         n_chg = 0;
    int         chg_at[4];
    logic [7:0] chg_val[4];
    string      hexchars = "0123456789ABCDEF";

    counter_uart_reporter #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] frame_byte(input logic [7:0] v, input int idx);
        case (idx)
            0:       return hexchars[int'(v[7:4])];
            1:       return hexchars[int'(v[3:0])];
            2:       return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    // Expected line level k cycles after the start bit of the frame begins
    function automatic logic frame_bit(input logic [7:0] v, input int k);
        int         pos;
        logic [7:0] by;
        pos = (k % BYTE_CYC) / DIV;
        by  = frame_byte(v, k / BYTE_CYC);
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return by[pos-1];
    endfunction

    // Called just after the edge on which tx fell. Applies the scheduled
    // value changes while the frame runs and ends on the frame_done cycle.
    task automatic run_frame(input logic [7:0] snap);
        int         bad_wave;
        int         bad_busy;
        int         bad_done;
        int         pos;
        logic [7:0] got[4];
        bad_wave = 0;
        bad_busy = 0;
        bad_done = 0;
        for (int b = 0; b < 4; b++) got[b] = 8'hxx;
        for (int k = 0; k < FRAME_CYC; k++) begin
            pos = (k % BYTE_CYC) / DIV;
            if (tx !== frame_bit(snap, k)) bad_wave++;
            if (busy !== 1'b1) bad_busy++;
            if (frame_done !== 1'b0) bad_done++;
            if (pos >= 1 && pos <= 8 && (k % DIV) == DIV / 2) got[k / BYTE_CYC][pos-1] = tx;
            for (int i = 0; i < n_chg; i++) begin
                if (chg_at[i] == k) value = chg_val[i];
            end
            tick();
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (got[b] !== frame_byte(snap, b)) begin
                failures++;
                $display("FAIL frame_byte%0d (value %h): got %h expected %h", b, snap, got[b], frame_byte(snap, b));
            end
        end
        checks++;
        if (bad_wave != 0) begin
            failures++;
            $display("FAIL frame_wave (value %h): %0d cycles wrong, expected 0", snap, bad_wave);
        end
        checks++;
        if (bad_busy != 0 || bad_done != 0) begin
            failures++;
            $display("FAIL frame_flags (value %h): busy low %0d cycles, early frame_done %0d cycles, expected 0/0", snap, bad_busy, bad_done);
        end
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
            failures++;
            $display("FAIL frame_end (value %h): frame_done=%b busy=%b tx=%b expected 1 0 1", snap, frame_done, busy, tx);
        end
        n_chg     = 0;
        sent_last = snap;
    endtask

    // Changes value while idle and follows the resulting frame
    task automatic send_idle_change(input logic [7:0] v);
        repeat ($urandom_range(3, 12)) tick();
        value = v;
        tick();
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL change_edge1 (value %h): tx=%b busy=%b expected 1 0", v, tx, busy);
        end
        tick();
        checks++;
        if (tx !== 1'b0) begin
            failures++;
            $display("FAIL change_edge2_fall (value %h): tx=%b expected 0", v, tx);
        end
        run_frame(v);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        value = 8'h00;
        repeat (3) tick();
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: tx=%b busy=%b frame_done=%b expected 1 0 0", tx, busy, frame_done);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_fall: tx=%b busy=%b expected 0 1", tx, busy);
        end
        run_frame(8'h00);
    endtask

    task automatic test_change();
        logic [7:0] v;
        for (int i = 0; i < 4; i++) begin
            v = (i == 0) ? 8'hA5 : 8'($urandom);
            if (v == sent_last) v = ~v;
            send_idle_change(v);
        end
    endtask

    task automatic test_coalesce();
        logic [7:0] v0;
        logic [7:0] fin;
        int         bad;
        for (int s = 0; s < 3; s++) begin
            v0 = 8'($urandom);
            if (s == 0 && v0 == 8'h03) v0 = 8'h3C;
            if (v0 == sent_last) v0 = ~v0;
            n_chg     = 3;
            chg_at[0] = $urandom_range(10, 130);
            chg_at[1] = $urandom_range(140, 260);
            chg_at[2] = $urandom_range(270, FRAME_CYC - 1);
            if (s == 0) begin
                chg_val[0] = 8'h01; chg_val[1] = 8'h02; chg_val[2] = 8'h03;
            end else if (s == 1) begin
                chg_val[0] = 8'($urandom); chg_val[1] = 8'($urandom); chg_val[2] = v0;
            end else begin
                chg_val[0] = 8'($urandom); chg_val[1] = 8'($urandom); chg_val[2] = 8'($urandom);
            end
            fin = chg_val[2];
            send_idle_change(v0);
            if (fin != v0) begin
                tick();
                checks++;
                if (tx !== 1'b0) begin
                    failures++;
                    $display("FAIL coalesce_restart (scenario %0d): tx=%b expected 0", s, tx);
                end
                run_frame(fin);
            end
            bad = 0;
            repeat (300) begin
                tick();
                if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL coalesce_no_extra (scenario %0d): %0d active cycles, expected 0", s, bad);
            end
        end
    endtask

    task automatic test_quiet();
        int bad;
        bad = 0;
        repeat (2000) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL quiet_idle: %0d active cycles, expected 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        logic [7:0] w;
        v = 8'($urandom);
        if (v == sent_last) v = ~v;
        value = v;
        tick();
        tick();
        checks++;
        if (tx !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_start: tx=%b expected 0", tx);
        end
        // Into the data bits of byte index 2
        repeat (2 * BYTE_CYC + 4 * DIV + 5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async: tx=%b busy=%b frame_done=%b expected 1 0 0", tx, busy, frame_done);
        end
        w     = 8'($urandom);
        value = w;
        tick();
        tick();
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_hold: tx=%b busy=%b expected 1 0", tx, busy);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (tx !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_restart: tx=%b expected 0", tx);
        end
        run_frame(w);
    endtask

    task automatic test_wrap();
        if (sent_last == 8'hFF) send_idle_change(8'h12);
        send_idle_change(8'hFF);
        send_idle_change(8'h00);
    endtask

    initial begin
        test_reset();
        test_change();
        test_coalesce();
        test_quiet();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
